// File: rtl/ddr_package.sv
// Shared types and constants for the DDR4 DIMM responder.
package ddr_package;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE
  } cmd_e;

  // Clocks per BL8 burst (two beats per clock).
  localparam int unsigned BL8_BEATS  = 4;
  // Storage index {bg,ba,row[1:0],col[5:3],beat[1:0]} -> 2048 words.
  localparam int unsigned IDX_W      = 11;
  localparam int unsigned PIPE_DEPTH = 32;

  typedef struct packed {
    logic             valid;
    logic             is_wr;
    logic [IDX_W-1:0] base;
  } pipe_ent_t;

  // Additive latency code: 00=0, 01=CL-1, 10=CL-2, 11 reserved (0).
  function automatic int unsigned al_decode(input logic [1:0] code, input int unsigned cl);
    case (code)
      2'b01:   return cl - 1;
      2'b10:   return cl - 2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/ddr_resp_lat_pipe.sv
// Latency shift pipeline: every accepted CAS enters stage 0 and is tapped at
// fixed stages to produce read, strobe and write windows.
module ddr_resp_lat_pipe
  import ddr_package::*;
#(
  parameter int unsigned RL    = 13,
  parameter int unsigned WL    = 10,
  parameter int unsigned R_PRE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             push_wr,
  input  logic [IDX_W-1:0] push_base,
  output logic             rd_hit,
  output logic [IDX_W-1:0] rd_idx,
  output logic             dqs_hit,
  output logic             wr_hit,
  output logic [IDX_W-1:0] wr_idx
);

  // An entry sits in stage j during cycle T+j+1. Read outputs are registered
  // downstream, so read taps sit one stage earlier than the visible cycle.
  localparam int unsigned RD_TAP  = RL - 2;
  localparam int unsigned DQS_TAP = RL - R_PRE - 2;
  localparam int unsigned DQS_END = RL + 1;
  localparam int unsigned WR_TAP  = WL - 1;

  pipe_ent_t pipe [PIPE_DEPTH];

  // Shift every entry one stage per clock; cleared asynchronously on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: push, is_wr: push_wr, base: push_base};
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Tap decode; tCCD >= burst length guarantees at most one hit per window.
  always_comb begin
    rd_hit  = 1'b0;
    rd_idx  = '0;
    dqs_hit = 1'b0;
    wr_hit  = 1'b0;
    wr_idx  = '0;
    for (int unsigned b = 0; b < BL8_BEATS; b++) begin
      if (pipe[RD_TAP+b].valid && !pipe[RD_TAP+b].is_wr) begin
        rd_hit = 1'b1;
        rd_idx = pipe[RD_TAP+b].base + IDX_W'(b);
      end
      if (pipe[WR_TAP+b].valid && pipe[WR_TAP+b].is_wr) begin
        wr_hit = 1'b1;
        wr_idx = pipe[WR_TAP+b].base + IDX_W'(b);
      end
    end
    for (int unsigned s = DQS_TAP; s <= DQS_END; s++) begin
      if (pipe[s].valid && !pipe[s].is_wr) dqs_hit = 1'b1;
    end
  end

endmodule

// File: rtl/ddr_dimm_resp.sv
// DDR4 DIMM responder: command decode, bank table, BL8 storage and read drive.
module ddr_dimm_resp
  import ddr_package::*;
#(
  parameter int unsigned tCAS_R = 13,
  parameter int unsigned tCAS_W = 10,
  parameter logic [1:0]  AL_DLY = 2'b00,
  parameter int unsigned R_PRE  = 1,
  parameter int unsigned W_PRE  = 1,
  parameter int unsigned tCCD   = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cs_n,
  input  logic        act_n,
  input  logic        ras_n_a16,
  input  logic        cas_n_a15,
  input  logic        we_n_a14,
  input  logic [1:0]  bg,
  input  logic [1:0]  ba,
  input  logic [13:0] addr,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        dqs_oe,
  output logic [15:0] open_banks,
  output logic        protocol_err
);

  localparam int unsigned AL    = al_decode(AL_DLY, tCAS_R);
  localparam int unsigned RL    = AL + tCAS_R;
  localparam int unsigned WL    = AL + tCAS_W;
  localparam int unsigned CCD_W = $clog2(tCCD + 1);

  // Latency windows must fit inside the pipeline and preambles before data.
  if (RL < R_PRE + 2 || RL + 1 >= PIPE_DEPTH || WL < W_PRE || WL < 1 ||
      WL + 2 >= PIPE_DEPTH || tCCD < BL8_BEATS) begin : g_latency_range
    $error("ddr_dimm_resp: latency parameters outside pipeline range");
  end

  cmd_e             cmd;
  logic [3:0]       bank;
  logic             bank_open;
  logic             cas_ok;
  logic             err_now;
  logic             push;
  logic [IDX_W-1:0] push_base;
  logic [CCD_W-1:0] ccd_cnt;
  logic [16:0]      row_tbl [16];
  logic [16:0]      cur_row;
  logic             unused_row_hi;
  logic [15:0]      mem [2**IDX_W];
  logic             rd_hit, dqs_hit, wr_hit;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  assign bank          = {bg, ba};
  assign bank_open     = open_banks[bank];
  assign cur_row       = row_tbl[bank];
  assign unused_row_hi = ^cur_row[16:2];

  // Command decode and legality checks.
  always_comb begin
    cmd = CMD_NOP;
    if (!cs_n) begin
      if (!act_n) cmd = CMD_ACT;
      else begin
        case ({ras_n_a16, cas_n_a15, we_n_a14})
          3'b101:  cmd = CMD_RD;
          3'b100:  cmd = CMD_WR;
          3'b010:  cmd = CMD_PRE;
          default: cmd = CMD_NOP;
        endcase
      end
    end
    cas_ok    = bank_open && (ccd_cnt == '0);
    push      = (cmd == CMD_RD || cmd == CMD_WR) && cas_ok;
    err_now   = (cmd == CMD_ACT && bank_open) ||
                ((cmd == CMD_RD || cmd == CMD_WR) && !cas_ok);
    push_base = {bank, cur_row[1:0], addr[5:3], 2'b00};
  end

  // Bank table, tCCD spacing counter and registered read-side outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      open_banks   <= '0;
      ccd_cnt      <= '0;
      protocol_err <= 1'b0;
      dq_oe        <= 1'b0;
      dqs_oe       <= 1'b0;
      dq_out       <= '0;
    end else begin
      case (cmd)
        CMD_ACT: if (!bank_open) open_banks[bank] <= 1'b1;
        CMD_PRE: begin
          if (addr[10]) open_banks <= '0;
          else          open_banks[bank] <= 1'b0;
        end
        CMD_RD, CMD_WR: if (cas_ok && addr[10]) open_banks[bank] <= 1'b0;
        default: ;
      endcase
      if (push)               ccd_cnt <= CCD_W'(tCCD - 1);
      else if (ccd_cnt != '0) ccd_cnt <= ccd_cnt - 1'b1;
      protocol_err <= err_now;
      dq_oe        <= rd_hit;
      dqs_oe       <= dqs_hit;
      dq_out       <= rd_hit ? mem[rd_idx] : '0;
    end
  end

  // Row latch on a legal ACT; not part of the reset domain.
  always_ff @(posedge clock) begin
    if (cmd == CMD_ACT && !bank_open)
      row_tbl[bank] <= {ras_n_a16, cas_n_a15, we_n_a14, addr};
  end

  // Write-data retire into storage; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_hit) mem[wr_idx] <= dq_in;
  end

  ddr_resp_lat_pipe #(
    .RL    (RL),
    .WL    (WL),
    .R_PRE (R_PRE)
  ) u_lat_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_wr   (cmd == CMD_WR),
    .push_base (push_base),
    .rd_hit    (rd_hit),
    .rd_idx    (rd_idx),
    .dqs_hit   (dqs_hit),
    .wr_hit    (wr_hit),
    .wr_idx    (wr_idx)
  );

endmodule

// File: tb/tb_ddr_dimm_resp.sv
// Directed bench for ddr_dimm_resp: default instance plus an AL=CL-1 instance.
module tb_ddr_dimm_resp;

  localparam logic [2:0] RCW_RD  = 3'b101;
  localparam logic [2:0] RCW_WR  = 3'b100;
  localparam logic [2:0] RCW_PRE = 3'b010;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
  logic [1:0]  bg, ba;
  logic [13:0] addr;
  logic [15:0] dq_in;
  logic [15:0] dq_out, dq_out_al;
  logic        dq_oe, dq_oe_al, dqs_oe, dqs_oe_al, protocol_err, protocol_err_al;
  logic [15:0] open_banks, open_banks_al;

  int n_checks = 0;
  int n_fail   = 0;
  int rec_k    = 0;

  logic        oe_r  [64];
  logic        dqs_r [64];
  logic        err_r [64];
  logic [15:0] dq_r  [64];
  logic        oe2_r [64];
  logic [15:0] dq2_r [64];
  logic [15:0] pat   [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  always #5 clock = ~clock;

  ddr_dimm_resp u_dut (
    .clock(clock), .reset_n(reset_n), .cs_n(cs_n), .act_n(act_n),
    .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14),
    .bg(bg), .ba(ba), .addr(addr), .dq_in(dq_in), .dq_out(dq_out),
    .dq_oe(dq_oe), .dqs_oe(dqs_oe), .open_banks(open_banks),
    .protocol_err(protocol_err)
  );

  ddr_dimm_resp #(.AL_DLY(2'b01)) u_dut_al (
    .clock(clock), .reset_n(reset_n), .cs_n(cs_n), .act_n(act_n),
    .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14),
    .bg(bg), .ba(ba), .addr(addr), .dq_in(dq_in), .dq_out(dq_out_al),
    .dq_oe(dq_oe_al), .dqs_oe(dqs_oe_al), .open_banks(open_banks_al),
    .protocol_err(protocol_err_al)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic act, input logic [2:0] rcw, input logic [3:0] bank,
                       input logic [13:0] a);
    cs_n = 1'b0;
    act_n = act;
    {ras_n_a16, cas_n_a15, we_n_a14} = rcw;
    {bg, ba} = bank;
    addr = a;
  endtask

  task automatic nop();
    cs_n = 1'b1;
    act_n = 1'b1;
    {ras_n_a16, cas_n_a15, we_n_a14} = 3'b111;
    {bg, ba} = 4'd0;
    addr = '0;
  endtask

  // Advance to the next falling edge and log outputs for cycle T+rec_k.
  task automatic step();
    @(negedge clock);
    rec_k++;
    if (rec_k < 64) begin
      oe_r[rec_k]  = dq_oe;
      dqs_r[rec_k] = dqs_oe;
      err_r[rec_k] = protocol_err;
      dq_r[rec_k]  = dq_out;
      oe2_r[rec_k] = dq_oe_al;
      dq2_r[rec_k] = dq_out_al;
    end
  endtask

  function automatic int count_oe(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (oe_r[i]) n++;
    return n;
  endfunction

  function automatic int count_dqs(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (dqs_r[i]) n++;
    return n;
  endfunction

  function automatic int count_err(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (err_r[i]) n++;
    return n;
  endfunction

  initial begin
    reset_n = 1'b0;
    nop();
    dq_in = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_open_banks", open_banks, 16'h0000);
    check_eq("rst_dq_oe", dq_oe, 1'b0);
    check_eq("rst_dqs_oe", dqs_oe, 1'b0);
    check_eq("rst_dq_out", dq_out, 16'h0000);
    check_eq("rst_err", protocol_err, 1'b0);

    // ACT bg=1 ba=2 row=3 on the first edge after release
    reset_n = 1'b1;
    drive(1'b0, 3'b000, 4'd6, 14'd3);
    step(); nop();
    check_eq("act_open", open_banks, 16'h0040);
    check_eq("act_err", protocol_err, 1'b0);
    step(); step();

    // WR col 8; data windows for WL=10 and WL=22
    drive(1'b1, RCW_WR, 4'd6, 14'd8);
    rec_k = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      nop();
      if (rec_k >= 10 && rec_k <= 13)      dq_in = pat[rec_k-10];
      else if (rec_k >= 22 && rec_k <= 25) dq_in = pat[rec_k-22];
      else                                 dq_in = 16'hDEAD;
    end
    check_eq("wr_err", err_r[1], 1'b0);

    // RD col 8
    drive(1'b1, RCW_RD, 4'd6, 14'd8);
    rec_k = 0;
    for (int i = 0; i < 36; i++) begin step(); nop(); end
    check_eq("rd_oe_before", oe_r[12], 1'b0);
    check_eq("rd_dq_idle", dq_r[12], 16'h0000);
    check_eq("rd_dqs_pre_off", dqs_r[11], 1'b0);
    check_eq("rd_dqs_pre_on", dqs_r[12], 1'b1);
    for (int b = 0; b < 4; b++) begin
      check_eq("rd_oe", oe_r[13+b], 1'b1);
      check_eq("rd_data", dq_r[13+b], pat[b]);
    end
    check_eq("rd_oe_after", oe_r[17], 1'b0);
    check_eq("rd_dqs_after", dqs_r[17], 1'b0);
    check_eq("al_oe_before", oe2_r[24], 1'b0);
    check_eq("al_oe_first", oe2_r[25], 1'b1);
    check_eq("al_data_first", dq2_r[25], 16'h1111);
    check_eq("al_data_last", dq2_r[28], 16'h4444);

    // RD to closed bank 5
    drive(1'b1, RCW_RD, 4'd5, 14'd8);
    rec_k = 0;
    for (int i = 0; i < 36; i++) begin step(); nop(); end
    check_eq("closed_err", err_r[1], 1'b1);
    check_eq("closed_err_pulse", err_r[2], 1'b0);
    check_eq("closed_no_oe", count_oe(1, 36), 0);

    // Two RDs 4 clocks apart -> 8 gapless beats
    drive(1'b1, RCW_RD, 4'd6, 14'd8);
    rec_k = 0;
    for (int i = 0; i < 36; i++) begin
      step();
      if (rec_k == 4) drive(1'b1, RCW_RD, 4'd6, 14'd8); else nop();
    end
    check_eq("b2b_count", count_oe(1, 36), 8);
    check_eq("b2b_gapless", count_oe(13, 20), 8);
    check_eq("b2b_data2", dq_r[17], 16'h1111);
    check_eq("b2b_data_end", dq_r[20], 16'h4444);
    check_eq("b2b_no_err", count_err(1, 36), 0);

    // Two RDs 3 clocks apart -> second dropped
    drive(1'b1, RCW_RD, 4'd6, 14'd8);
    rec_k = 0;
    for (int i = 0; i < 36; i++) begin
      step();
      if (rec_k == 3) drive(1'b1, RCW_RD, 4'd6, 14'd8); else nop();
    end
    check_eq("ccd_err", err_r[4], 1'b1);
    check_eq("ccd_err_count", count_err(1, 36), 1);
    check_eq("ccd_dropped", count_oe(1, 36), 4);

    // Open banks 0,5,10,15 (6 already open), ACT-to-open, PRE all
    drive(1'b0, 3'b000, 4'd0, 14'd1);  step();
    drive(1'b0, 3'b000, 4'd5, 14'd2);  step();
    drive(1'b0, 3'b000, 4'd10, 14'd3); step();
    drive(1'b0, 3'b000, 4'd15, 14'd0); step(); nop();
    check_eq("banks4_open", open_banks, 16'h8461);
    drive(1'b0, 3'b001, 4'd5, 14'd7);  step(); nop();
    check_eq("act_open_err", protocol_err, 1'b1);
    check_eq("act_open_keep", open_banks, 16'h8461);
    drive(1'b1, RCW_PRE, 4'd0, 14'h0400); step(); nop();
    check_eq("pre_all", open_banks, 16'h0000);
    check_eq("pre_all_err", protocol_err, 1'b0);
    drive(1'b1, RCW_PRE, 4'd9, 14'd0); step(); nop();
    check_eq("pre_closed_legal", protocol_err, 1'b0);

    // RD with auto-precharge closes the bank; next CAS there is illegal
    drive(1'b0, 3'b000, 4'd3, 14'd0); step();
    drive(1'b1, RCW_RD, 4'd3, 14'h0408); step(); nop();
    check_eq("ap_err", protocol_err, 1'b0);
    check_eq("ap_closed", open_banks, 16'h0000);
    repeat (4) step();
    drive(1'b1, RCW_WR, 4'd3, 14'd8); step(); nop();
    check_eq("ap_cas_err", protocol_err, 1'b1);
    repeat (36) step();

    // Reset during the second read beat
    drive(1'b0, 3'b000, 4'd6, 14'd3); step(); nop(); step();
    drive(1'b1, RCW_RD, 4'd6, 14'd8);
    rec_k = 0;
    for (int i = 0; i < 14; i++) begin step(); nop(); end
    check_eq("mid_oe", oe_r[14], 1'b1);
    check_eq("mid_data", dq_r[14], 16'h2222);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_oe", dq_oe, 1'b0);
    check_eq("mid_rst_dqs", dqs_oe, 1'b0);
    check_eq("mid_rst_dq", dq_out, 16'h0000);
    check_eq("mid_rst_banks", open_banks, 16'h0000);
    step(); step();
    reset_n = 1'b1;
    rec_k = 0;
    for (int i = 0; i < 36; i++) step();
    check_eq("post_rst_oe", count_oe(1, 36), 0);
    check_eq("post_rst_dqs", count_dqs(1, 36), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
